// File: rtl/latency_memory_if.sv
`default_nettype none
// ============================================================================
// latency_memory_if : request/ready bus between a cache and latency_memory
// Revision          : 1.0
// ============================================================================
interface latency_memory_if #(
    parameter int WORDS  = 4,
    parameter int ADDR_W = 28
) ();
    localparam int LW = 32 * WORDS;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LW-1:0]     mem_wdata;
    logic [WORDS-1:0]  mem_wmask;
    logic [LW-1:0]     mem_rdata;
    logic              mem_ready;
    logic              mem_err;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata, mem_ready, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata, mem_ready, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/latency_memory.sv
`default_nettype none
// ============================================================================
// latency_memory : line memory with counter-based access latency and masks
// Revision       : 1.0
// ============================================================================
module latency_memory #(
    parameter int DEPTH        = 64,
    parameter int WORDS        = 4,
    parameter int ADDR_W       = 28,
    parameter int LATENCY      = 15,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    latency_memory_if.slave  bus
);
    localparam int LW    = 32 * WORDS;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              req_read;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LW-1:0]     req_wdata;
    logic [WORDS-1:0]  req_wmask;
    logic [LW-1:0]     rdata;
    logic              ready;
    logic              err;

    logic [LW-1:0]     mem [DEPTH];

    logic              fire;
    logic              bad;
    logic [IDX_W-1:0]  idx;

    assign fire = (state == ST_WAIT) && (cnt == '0);
    assign bad  = (req_read && req_write) || ({1'b0, req_addr} >= DEPTH_EXT);
    assign idx  = req_addr[IDX_W-1:0];

    assign bus.mem_rdata = rdata;
    assign bus.mem_ready = ready;
    assign bus.mem_err   = err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            req_read  <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wmask <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        req_read  <= bus.mem_read;
                        req_write <= bus.mem_write;
                        req_addr  <= bus.mem_addr;
                        req_wdata <= bus.mem_wdata;
                        req_wmask <= bus.mem_wmask;
                        cnt       <= CNT_LOAD;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                        ready <= 1'b1;
                        err   <= bad;
                        // A write-only response leaves the last read line visible.
                        if (bad) begin
                            rdata <= '0;
                        end else if (req_read) begin
                            rdata <= mem[idx];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Reset takes priority, so an abandoned write never reaches the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (CLEAR_ON_RST != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
        end else if (fire && req_write && !bad) begin
            for (int k = 0; k < WORDS; k++) begin
                if (req_wmask[k]) begin
                    mem[idx][32*k +: 32] <= req_wdata[32*k +: 32];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_latency_memory.sv
`default_nettype none
// ============================================================================
// tb_latency_memory : scoreboard bench over three parameterisations
// Revision          : 1.0
// ============================================================================
module tb_latency_memory;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    latency_memory_if #(.WORDS(4), .ADDR_W(28)) ifa ();
    latency_memory_if #(.WORDS(4), .ADDR_W(28)) ifb ();
    latency_memory_if #(.WORDS(8), .ADDR_W(28)) ifc ();

    latency_memory #(.DEPTH(64), .WORDS(4), .ADDR_W(28), .LATENCY(15), .CLEAR_ON_RST(1))
        dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa.slave));
    latency_memory #(.DEPTH(64), .WORDS(4), .ADDR_W(28), .LATENCY(15), .CLEAR_ON_RST(0))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb.slave));
    latency_memory #(.DEPTH(16), .WORDS(8), .ADDR_W(28), .LATENCY(1), .CLEAR_ON_RST(1))
        dut_c (.clk(clk), .rst_n(rst_c), .bus(ifc.slave));

    typedef struct {
        logic [255:0] rdata;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           compared   = 0;
    int           mismatched = 0;
    logic [255:0] last[3];
    int           last_e[3];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return ifa.mem_ready;
            1:       return ifb.mem_ready;
            default: return ifc.mem_ready;
        endcase
    endfunction

    function automatic logic err_of(input int sel);
        case (sel)
            0:       return ifa.mem_err;
            1:       return ifb.mem_err;
            default: return ifc.mem_err;
        endcase
    endfunction

    function automatic logic [255:0] rdata_of(input int sel);
        case (sel)
            0:       return 256'(ifa.mem_rdata);
            1:       return 256'(ifb.mem_rdata);
            default: return ifc.mem_rdata;
        endcase
    endfunction

    task automatic drive(input int sel, input logic rd, input logic wr, input logic [27:0] addr,
                         input logic [255:0] wdata, input logic [7:0] wmask);
        case (sel)
            0: begin
                ifa.mem_read = rd; ifa.mem_write = wr; ifa.mem_addr = addr;
                ifa.mem_wdata = wdata[127:0]; ifa.mem_wmask = wmask[3:0];
            end
            1: begin
                ifb.mem_read = rd; ifb.mem_write = wr; ifb.mem_addr = addr;
                ifb.mem_wdata = wdata[127:0]; ifb.mem_wmask = wmask[3:0];
            end
            default: begin
                ifc.mem_read = rd; ifc.mem_write = wr; ifc.mem_addr = addr;
                ifc.mem_wdata = wdata; ifc.mem_wmask = wmask;
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the pulse.
    task automatic txn(input int sel, input string tag, input logic rd, input logic wr,
                       input logic [27:0] addr, input logic [255:0] wdata, input logic [7:0] wmask,
                       input logic [255:0] rd_exp, input bit b2b, input bit hold);
        exp_t e;
        int   k;
        int   lat;
        int   depth;
        bit   got;
        lat     = (sel == 2) ? 1 : 15;
        depth   = (sel == 2) ? 16 : 64;
        e.err   = (rd && wr) || (int'(addr) >= depth);
        e.rdata = e.err ? 256'd0 : (rd ? rd_exp : last[sel]);
        drive(sel, rd, wr, addr, wdata, wmask);
        sb.push_back(e);
        @(posedge clk);
        if (b2b) check({tag, " spacing"}, 256'(cyc - last_e[sel]), 256'(lat + 2));
        last_e[sel] = cyc;
        got = 1'b0;
        k   = 0;
        while (!got && k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            got = ready_of(sel);
        end
        e = sb.pop_front();
        check({tag, " ready"}, 256'(got), 256'd1);
        if (got) begin
            check({tag, " latency"}, 256'(k), 256'(lat));
            check({tag, " rdata"}, rdata_of(sel), e.rdata);
            check({tag, " err"}, 256'(err_of(sel)), 256'(e.err));
        end
        last[sel] = e.rdata;
        if (!hold) drive(sel, 1'b0, 1'b0, 28'd0, 256'd0, 8'd0);
        @(negedge clk);
        check({tag, " ready_low"}, 256'(ready_of(sel)), 256'd0);
    endtask

    localparam logic [255:0] W3   = 256'h44444444_33333333_22222222_11111111;
    localparam logic [255:0] AAAA = 256'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
    localparam logic [255:0] BBBB = 256'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;
    localparam logic [255:0] MIX  = 256'hAAAAAAAA_BBBBBBBB_AAAAAAAA_BBBBBBBB;
    localparam logic [255:0] PRE  = 256'h0000CAFE_0000BEEF_0000F00D_0000D00D;
    localparam logic [255:0] NEWV = 256'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    localparam logic [255:0] D256 =
        256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

    initial begin
        bit noready;
        for (int i = 0; i < 3; i++) begin
            last[i]   = '0;
            last_e[i] = 0;
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 28'd0, 256'd0, 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        check("rst ready", 256'(ifa.mem_ready), 256'd0);
        check("rst err",   256'(ifa.mem_err),   256'd0);
        check("rst rdata", 256'(ifa.mem_rdata), 256'd0);

        txn(0, "rd5",      1'b1, 1'b0, 28'd5,  256'd0, 8'h0, 256'd0, 1'b0, 1'b0);
        txn(0, "wr3",      1'b0, 1'b1, 28'd3,  W3,     8'hF, 256'd0, 1'b1, 1'b0);
        txn(0, "rd3",      1'b1, 1'b0, 28'd3,  256'd0, 8'h0, W3,     1'b1, 1'b0);
        txn(0, "both3",    1'b1, 1'b1, 28'd3,  BBBB,   8'hF, 256'd0, 1'b1, 1'b0);
        txn(0, "rd3_post", 1'b1, 1'b0, 28'd3,  256'd0, 8'h0, W3,     1'b1, 1'b0);
        txn(0, "rd64",     1'b1, 1'b0, 28'd64, 256'd0, 8'h0, 256'd0, 1'b1, 1'b0);
        txn(0, "wr7_pre",  1'b0, 1'b1, 28'd7,  AAAA,   8'hF, 256'd0, 1'b0, 1'b0);
        txn(0, "wr7_mask", 1'b0, 1'b1, 28'd7,  BBBB,   8'h5, 256'd0, 1'b1, 1'b0);
        txn(0, "rd7",      1'b1, 1'b0, 28'd7,  256'd0, 8'h0, MIX,    1'b1, 1'b0);
        txn(0, "wr7_zero", 1'b0, 1'b1, 28'd7,  NEWV,   8'h0, 256'd0, 1'b1, 1'b0);
        txn(0, "rd7_post", 1'b1, 1'b0, 28'd7,  256'd0, 8'h0, MIX,    1'b1, 1'b0);

        // Abandon a write part-way through its wait and confirm nothing lands.
        txn(1, "b_pre", 1'b0, 1'b1, 28'd2, PRE, 8'hF, 256'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b1, 28'd2, NEWV, 8'hF);
        @(posedge clk);
        noready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifb.mem_ready) noready = 1'b0;
        end
        rst_b = 1'b0;
        drive(1, 1'b0, 1'b0, 28'd0, 256'd0, 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        check("b_rst rdata", 256'(ifb.mem_rdata), 256'd0);
        last[1] = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifb.mem_ready) noready = 1'b0;
        end
        check("b_abandon no_ready", 256'(noready), 256'd1);
        txn(1, "b_rd2", 1'b1, 1'b0, 28'd2, 256'd0, 8'h0, PRE, 1'b0, 1'b0);

        txn(2, "c_wr15", 1'b0, 1'b1, 28'd15, D256,   8'hFF, 256'd0, 1'b0, 1'b0);
        txn(2, "c_rd15", 1'b1, 1'b0, 28'd15, 256'd0, 8'h00, D256,   1'b1, 1'b0);
        txn(2, "c_hold", 1'b1, 1'b0, 28'd15, 256'd0, 8'h00, D256,   1'b1, 1'b1);
        txn(2, "c_again",1'b1, 1'b0, 28'd15, 256'd0, 8'h00, D256,   1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", compared);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
